// File: rtl/sr_drive_if.sv
// Request/drive bundle between the SR latch driver and its environment.
interface sr_drive_if;
    logic set_req;
    logic clr_req;
    logic s;
    logic r;
    logic busy;
    logic q_exp;
    logic conflict;

    modport master (
        output set_req, clr_req,
        input  s, r, busy, q_exp, conflict
    );

    modport slave (
        input  set_req, clr_req,
        output s, r, busy, q_exp, conflict
    );
endinterface

// File: rtl/sr_drive_ctrl.sv
// SR latch driver: synchronizes and debounces set/clear requests, issues
// width-controlled s/r pulses, drops conflicting requests and tracks expected q.
module sr_drive_ctrl #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned PULSE_W    = 3,
    parameter int unsigned GAP_W      = 1
) (
    input  logic       clk,
    input  logic       rst,
    sr_drive_if.slave  bus
);
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_W - 1);

    typedef enum logic [1:0] {IDLE, SET_P, CLR_P, GAP} state_t;

    // Index 0 is the set path, index 1 the clear path.
    logic [1:0]    raw;
    logic [1:0]    sync1, sync2, deb, deb_d, rise;
    logic [CW-1:0] dcnt [2];

    state_t        state, state_n;
    logic [CW-1:0] pcnt, pcnt_n;
    logic [1:0]    pend, pend_n;
    logic          q_exp_n, conflict_n;

    assign raw  = {bus.clr_req, bus.set_req};
    assign rise = deb & ~deb_d;

    // Two-flop synchronizers followed by stable-count debounce.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (dcnt[i] == DEB_LAST) begin
                        deb[i]  <= sync2[i];
                        dcnt[i] <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + CW'(1);
                    end
                end else begin
                    dcnt[i] <= '0;
                end
            end
        end
    end

    // Command sequencing; a rise seen this cycle counts as already pending.
    always_comb begin
        state_n    = state;
        pcnt_n     = pcnt;
        pend_n     = pend | rise;
        q_exp_n    = bus.q_exp;
        conflict_n = 1'b0;
        case (state)
            IDLE: begin
                if (pend_n[0] && pend_n[1]) begin
                    conflict_n = 1'b1;
                    pend_n     = '0;
                end else if (pend_n[0]) begin
                    state_n   = SET_P;
                    pcnt_n    = '0;
                    pend_n[0] = 1'b0;
                end else if (pend_n[1]) begin
                    state_n   = CLR_P;
                    pcnt_n    = '0;
                    pend_n[1] = 1'b0;
                end
            end
            SET_P, CLR_P: begin
                if (pcnt == PULSE_LAST) begin
                    pcnt_n  = '0;
                    state_n = (GAP_W == 0) ? IDLE : GAP;
                end else begin
                    pcnt_n = pcnt + CW'(1);
                end
            end
            GAP: begin
                if (pcnt == GAP_LAST) begin
                    pcnt_n  = '0;
                    state_n = IDLE;
                end else begin
                    pcnt_n = pcnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                pcnt_n  = '0;
            end
        endcase
        // q_exp reflects the command from the first cycle of its final pulse cycle.
        if (state_n == SET_P && pcnt_n == PULSE_LAST) q_exp_n = 1'b1;
        if (state_n == CLR_P && pcnt_n == PULSE_LAST) q_exp_n = 1'b0;
    end

    // Outputs are registered from next-state so they align with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pcnt         <= '0;
            pend         <= '0;
            bus.s        <= 1'b0;
            bus.r        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.q_exp    <= 1'b0;
            bus.conflict <= 1'b0;
        end else begin
            state        <= state_n;
            pcnt         <= pcnt_n;
            pend         <= pend_n;
            bus.s        <= (state_n == SET_P);
            bus.r        <= (state_n == CLR_P);
            bus.busy     <= (state_n != IDLE);
            bus.q_exp    <= q_exp_n;
            bus.conflict <= conflict_n;
        end
    end
endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Bench for sr_drive_ctrl: two parameter sets driven in parallel against a
// timestamp-based command model, plus hand-computed spot checks.
module tb_sr_drive_ctrl;
    localparam int DEB_A [2] = '{4, 1};
    localparam int PW_A  [2] = '{3, 1};
    localparam int GW_A  [2] = '{1, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;

    always #5 clk = ~clk;

    sr_drive_if bus0 ();
    sr_drive_if bus1 ();

    assign bus0.set_req = set_req;
    assign bus0.clr_req = clr_req;
    assign bus1.set_req = set_req;
    assign bus1.clr_req = clr_req;

    sr_drive_ctrl u0 (.clk(clk), .rst(rst), .bus(bus0));
    sr_drive_ctrl #(.DEB_CYCLES(1), .PULSE_W(1), .GAP_W(0)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [1:0] s_o, r_o, busy_o, q_o, cf_o;
    assign s_o    = {bus1.s,        bus0.s};
    assign r_o    = {bus1.r,        bus0.r};
    assign busy_o = {bus1.busy,     bus0.busy};
    assign q_o    = {bus1.q_exp,    bus0.q_exp};
    assign cf_o   = {bus1.conflict, bus0.conflict};

    int total = 0;
    int bad   = 0;
    int en    = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, en);
        end
    endtask

    // Model state: deb/sync per input, pending flags, and the last issued command
    // as (start edge, kind). Everything else is derived from those timestamps.
    bit s1 [2], s2 [2], ds [2], dsd [2], c1 [2], c2 [2], dc [2], dcd [2];
    int rs [2], rc [2];
    bit ps [2], pc [2], act [2], kind [2], mq [2], mcf [2];
    int t0 [2], nd [2];
    bit exp_s [2], exp_r [2], exp_b [2];

    initial begin
        forever begin
            @(posedge clk);
            for (int g = 0; g < 2; g++) begin
                if (rst) begin
                    s1[g] = 0; s2[g] = 0; ds[g] = 0; dsd[g] = 0; rs[g] = 0;
                    c1[g] = 0; c2[g] = 0; dc[g] = 0; dcd[g] = 0; rc[g] = 0;
                    ps[g] = 0; pc[g] = 0; act[g] = 0; mq[g] = 0; mcf[g] = 0;
                    nd[g] = en + 1;
                end else begin
                    bit rise_s, rise_c;
                    rise_s = ds[g] && !dsd[g];
                    rise_c = dc[g] && !dcd[g];
                    mcf[g] = 0;
                    if (en >= nd[g]) begin
                        if ((ps[g] || rise_s) && (pc[g] || rise_c)) begin
                            mcf[g] = 1; ps[g] = 0; pc[g] = 0;
                        end else if (ps[g] || rise_s) begin
                            act[g] = 1; kind[g] = 1; t0[g] = en; ps[g] = 0;
                            nd[g] = en + PW_A[g] + GW_A[g] + 1;
                        end else if (pc[g] || rise_c) begin
                            act[g] = 1; kind[g] = 0; t0[g] = en; pc[g] = 0;
                            nd[g] = en + PW_A[g] + GW_A[g] + 1;
                        end
                    end else begin
                        ps[g] = ps[g] | rise_s;
                        pc[g] = pc[g] | rise_c;
                    end
                    // deb flips once sync2 has disagreed for DEB consecutive samples
                    dsd[g] = ds[g];
                    if (s2[g] != ds[g]) begin
                        rs[g]++;
                        if (rs[g] == DEB_A[g]) begin ds[g] = s2[g]; rs[g] = 0; end
                    end else rs[g] = 0;
                    dcd[g] = dc[g];
                    if (c2[g] != dc[g]) begin
                        rc[g]++;
                        if (rc[g] == DEB_A[g]) begin dc[g] = c2[g]; rc[g] = 0; end
                    end else rc[g] = 0;
                    s2[g] = s1[g]; s1[g] = set_req;
                    c2[g] = c1[g]; c1[g] = clr_req;
                    if (act[g] && en == t0[g] + PW_A[g] - 1) mq[g] = kind[g];
                end
                exp_s[g] = act[g] &&  kind[g] && en >= t0[g] && en < t0[g] + PW_A[g];
                exp_r[g] = act[g] && !kind[g] && en >= t0[g] && en < t0[g] + PW_A[g];
                exp_b[g] = act[g] && en >= t0[g] && en < t0[g] + PW_A[g] + GW_A[g];
            end
            en++;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        bit prev_cf [2];
        prev_cf[0] = 0; prev_cf[1] = 0;
        forever begin
            @(negedge clk);
            if (en > 0) begin
                for (int g = 0; g < 2; g++) begin
                    chk($sformatf("c%0d_s", g),        int'(s_o[g]),    int'(exp_s[g]));
                    chk($sformatf("c%0d_r", g),        int'(r_o[g]),    int'(exp_r[g]));
                    chk($sformatf("c%0d_busy", g),     int'(busy_o[g]), int'(exp_b[g]));
                    chk($sformatf("c%0d_q_exp", g),    int'(q_o[g]),    int'(mq[g]));
                    chk($sformatf("c%0d_conflict", g), int'(cf_o[g]),   int'(mcf[g]));
                    chk($sformatf("c%0d_s_and_r", g),  int'(s_o[g] & r_o[g]), 0);
                    if (prev_cf[g]) chk($sformatf("c%0d_cf_twice", g), int'(cf_o[g]), 0);
                    prev_cf[g] = cf_o[g];
                end
            end
        end
    end

    task automatic wn(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cnt_s, cnt_r, cnt_cf, cnt_b;
        wn(2);
        chk("rst_s", int'(s_o[0]), 0);
        chk("rst_busy", int'(busy_o[0]), 0);
        chk("rst_q", int'(q_o[0]), 0);
        rst = 1'b0;
        wn(3);

        // Set held from edge k: s after k+6..k+8, q_exp after k+8, idle after k+10.
        set_req = 1'b1;
        wn(6); chk("t1_s_early", int'(s_o[0]), 0);
        wn(1); chk("t1_s_1", int'(s_o[0]), 1); chk("t1_busy", int'(busy_o[0]), 1);
        wn(1); chk("t1_s_2", int'(s_o[0]), 1); chk("t1_q_mid", int'(q_o[0]), 0);
        wn(1); chk("t1_s_3", int'(s_o[0]), 1); chk("t1_q", int'(q_o[0]), 1);
        wn(1); chk("t1_s_off", int'(s_o[0]), 0); chk("t1_gap_busy", int'(busy_o[0]), 1);
        wn(1); chk("t1_idle", int'(busy_o[0]), 0); chk("t1_r", int'(r_o[0]), 0);
        wn(8);
        set_req = 1'b0;
        wn(10);

        // Short clear glitch is filtered, then a held clear issues one r pulse.
        clr_req = 1'b1; wn(3); clr_req = 1'b0; wn(15);
        chk("t2_glitch_q", int'(q_o[0]), 1);
        cnt_r = 0;
        clr_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) clr_req = 1'b0;
            wn(1);
            cnt_r += int'(r_o[0]);
        end
        chk("t2_r_cycles", cnt_r, 3);
        chk("t2_q", int'(q_o[0]), 0);

        // Simultaneous set and clear: single conflict pulse, no drive.
        cnt_s = 0; cnt_r = 0; cnt_cf = 0; cnt_b = 0;
        set_req = 1'b1; clr_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wn(1);
            cnt_s += int'(s_o[0]); cnt_r += int'(r_o[0]);
            cnt_cf += int'(cf_o[0]); cnt_b += int'(busy_o[0]);
        end
        chk("t3_conflict", cnt_cf, 1);
        chk("t3_s", cnt_s, 0);
        chk("t3_r", cnt_r, 0);
        chk("t3_busy", cnt_b, 0);
        chk("t3_q", int'(q_o[0]), 0);
        set_req = 1'b0; clr_req = 1'b0;
        wn(12);

        // Clear captured during the set pulse is serviced after GAP and one idle cycle.
        set_req = 1'b1;
        wn(1); clr_req = 1'b1;
        wn(10); chk("t4_idle_r", int'(r_o[0]), 0); chk("t4_idle_busy", int'(busy_o[0]), 0);
        chk("t4_q_set", int'(q_o[0]), 1);
        wn(1); chk("t4_r_1", int'(r_o[0]), 1);
        wn(2); chk("t4_r_3", int'(r_o[0]), 1); chk("t4_q", int'(q_o[0]), 0);
        wn(1); chk("t4_r_off", int'(r_o[0]), 0);
        wn(1); chk("t4_done", int'(busy_o[0]), 0);
        set_req = 1'b0; clr_req = 1'b0;
        wn(12);

        // Reset during the second s cycle; held set re-debounces from scratch.
        set_req = 1'b1;
        wn(8); chk("t5_pre_s", int'(s_o[0]), 1);
        rst = 1'b1;
        wn(1);
        chk("t5_s", int'(s_o[0]), 0); chk("t5_busy", int'(busy_o[0]), 0);
        chk("t5_q", int'(q_o[0]), 0);
        rst = 1'b0;
        wn(6); chk("t5_s_wait", int'(s_o[0]), 0);
        wn(1); chk("t5_s_again", int'(s_o[0]), 1);
        wn(4);
        set_req = 1'b0;
        wn(12);

        // Alternating set/clear every 6 cycles: q_exp toggles on the fast config.
        for (int i = 0; i < 8; i++) begin
            set_req = 1'b1; clr_req = 1'b0;
            wn(6); chk("t6_q_set", int'(q_o[1]), 1);
            set_req = 1'b0; clr_req = 1'b1;
            wn(6); chk("t6_q_clr", int'(q_o[1]), 0);
        end
        clr_req = 1'b0;
        wn(10);

        // Randomized phase with occasional simultaneous edges and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) set_req = ~set_req;
            if ($urandom_range(0, 7) == 0) clr_req = ~clr_req;
            if ($urandom_range(0, 19) == 0) begin
                set_req = 1'($urandom_range(0, 1));
                clr_req = set_req;
            end
            rst = ($urandom_range(0, 299) == 0);
            wn(1);
        end
        rst = 1'b0;
        wn(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sr_drive_ctrl.md
Name: sr_drive_ctrl

Overview:
- Upstream driver for the team's SR latch. It conditions two raw request lines (set, clear) and converts them into clean, width-controlled s/r pulses.
- Guarantees s and r are never high together. Holds the forbidden s=r=1 input off the latch and flags conflicting requests instead.
- Also tracks the expected latch state so the verification bench can check q against it.

Parameters:
- DEB_CYCLES, 4: consecutive stable cycles required before a debounced level changes (legal range 1..255).
- PULSE_W, 3: cycles s or r is held high per command (legal range 1..255).
- GAP_W, 1: forced idle cycles after each pulse, with s=r=0 (legal range 0..255).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- set_req  in  1  raw set request, asynchronous to clk
- clr_req  in  1  raw clear request, asynchronous to clk
- s  out  1  latch set drive, registered
- r  out  1  latch reset drive, registered
- busy  out  1  high whenever FSM is not in IDLE
- q_exp  out  1  expected latch q after the last completed command
- conflict  out  1  one-cycle pulse when a simultaneous set/clear is dropped

Behaviour:
- Reset: rst is sampled on the rising edge of clk.
  - All registers clear: s=0, r=0, busy=0, q_exp=0, conflict=0.
  - Synchronizers, debounce counters, debounced levels and pending flags all clear.
  - FSM goes to IDLE.
  - Reset mid-pulse drops s/r at that edge; no pending request survives.
- Synchronizer: each raw input passes through a 2-flop synchronizer (sync1 -> sync2).
- Debounce, per input:
  - Counter increments while sync2 != deb; it clears when they are equal.
  - deb takes sync2's value at the edge where the counter reaches DEB_CYCLES, and the counter clears at that edge.
  - Any disagreement shorter than DEB_CYCLES cycles leaves deb unchanged.
- Request capture:
  - A rising edge of deb (deb=1, deb_d=0) sets that input's one-deep pending flag.
  - Further rising edges while pending is set merge into it.
  - Falling edges of deb are ignored.
- FSM states and transitions:
  - IDLE: s=r=0, busy=0.
    - Only pend_set -> SET_P. Clear pend_set; s=1 from the next cycle.
    - Only pend_clr -> CLR_P. Clear pend_clr; r=1 from the next cycle.
    - Both pending (same cycle, or both captured during a pulse) -> stay in IDLE. Clear both flags and pulse conflict for 1 cycle; no s/r activity.
    - A rising edge that is being captured in the same cycle counts as pending.
  - SET_P: s=1 for exactly PULSE_W cycles. At the last cycle, q_exp<=1; then go to GAP, or to IDLE if GAP_W=0.
  - CLR_P: r=1 for exactly PULSE_W cycles. At the last cycle, q_exp<=0; then go to GAP, or to IDLE if GAP_W=0.
  - GAP: s=r=0, busy=1 for GAP_W cycles, then IDLE.
  - Requests arriving in SET_P/CLR_P/GAP are captured in the pending flags and serviced when IDLE is next reached.
- Timing: raw input first sampled high at edge k and held steady → deb=1 after edge k+1+DEB_CYCLES → s (or r) high after edge k+2+DEB_CYCLES.
- Minimum spacing between two s/r pulses: PULSE_W+GAP_W+1 cycles (one IDLE cycle is always taken).
- Repeated command: a set while q_exp=1 still issues a full s pulse, since the latch state is not read back.
- Invariants:
  - s&r is never 1.
  - busy = (state != IDLE).
  - conflict is never high in two consecutive cycles.
- Counter widths: 8 bits each; no wrap is reachable within the legal parameter ranges.

Test Plan:
- Defaults, rst 2 cycles, then set_req=1 held from edge 10 → s=1 during edges 16..18 (after edges 16,17,18), q_exp=1 after edge 18, busy low after GAP, r stays 0.
- After the set above, clr_req pulsed high for 3 cycles only (< DEB_CYCLES) → no r pulse, q_exp stays 1. Then clr_req held high for 10 cycles → exactly one r pulse of 3 cycles, q_exp=0.
- set_req and clr_req rise on the same edge, both held → conflict=1 for exactly one cycle, s=r=0 throughout, q_exp unchanged, busy stays 0.
- Set pulse in progress, clr_req debounces during SET_P → after SET_P and GAP, one IDLE cycle, then r=1 for 3 cycles. Final q_exp=0; s and r never overlap.
- rst asserted on the 2nd cycle of an s pulse → s=0, busy=0, q_exp=0 at that edge. A set request still held high re-debounces from scratch (s returns DEB_CYCLES+2 edges after rst deasserts).
- Parameters DEB_CYCLES=1, PULSE_W=1, GAP_W=0 with alternating set/clear each 6 cycles → single-cycle s/r pulses alternate and q_exp toggles. Checker asserts s&r==0 every cycle.
